// File: rtl/dma_ch_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dma_ch_arbiter
// Purpose  : Round-robin DMA channel arbiter with registered one-hot grant.
//            Optional grant watchdog enabled by macro DMA_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dma_ch_arbiter #(
    parameter int CH_NUM      = 4,
    parameter int CH_W        = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [CH_NUM-1:0] req_i,
    input  logic              done_i,
    output logic [CH_NUM-1:0] gnt_o,
    output logic [CH_W-1:0]   gnt_id_o,
`ifdef DMA_ARB_TIMEOUT_EN
    output logic              timeout_o,
`endif
    output logic              gnt_vld_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CH_W-1:0]     r_ptr, w_ptr_nxt;
    logic [CH_NUM-1:0]   r_gnt, w_gnt_nxt;
    logic [CH_W-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic                r_vld, w_vld_nxt;
    logic [CH_W-1:0]     w_win_id;
    logic [CH_W-1:0]     w_ptr_rel;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_timeout, w_timeout_nxt;
`endif

    // Rotating priority search: lowest offset from r_ptr wins, so scan high to low.
    always_comb begin
        w_win_id = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= CH_NUM) j = j - CH_NUM;
            if (req_i[j]) w_win_id = CH_W'(j);
        end
    end

    // Explicit compare keeps the wrap correct when CH_NUM is not a power of two.
    assign w_ptr_rel = (r_gnt_id == CH_W'(CH_NUM - 1)) ? '0 : r_gnt_id + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_vld_nxt    = r_vld;
`ifdef DMA_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (en_i && (|req_i)) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = CH_NUM'(1) << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_vld_nxt    = 1'b1;
`ifdef DMA_ARB_TIMEOUT_EN
                    w_cnt_nxt    = '0;
`endif
                end
            end
            GRANT: begin
                if (done_i) begin
                    w_state_nxt  = IDLE;
                    w_ptr_nxt    = w_ptr_rel;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_vld_nxt    = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = w_ptr_rel;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_vld_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_vld    <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_vld    <= w_vld_nxt;
`ifdef DMA_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_id_o  = r_gnt_id;
    assign gnt_vld_o = r_vld;
`ifdef DMA_ARB_TIMEOUT_EN
    assign timeout_o = r_timeout;
`endif

endmodule

`default_nettype wire
